pe_inst_loader: RTL
===================

Name: pe_inst_loader

Overview:
Write side of a PE's sort-instruction memory. Accepts a framed stream of 4-bit sort instructions from the host or configuration bus and stores the words addressed to this PE into a SORT_CYCLES-deep instruction store. The PE reads the store by step counter during SORT. Each mesh PE has one loader, on a shared broadcast bus, so schedules can be reloaded without resynthesis.

Parameters:
SORT_CYCLES, 222, instruction store depth; also the required frame length.
ADDR_WIDTH, 10, width of the PE index, write pointer and read address.
I, 0, index of the owning PE, used for destination match.
ERR_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
i_valid  input  1  stream word valid
o_ready  output  1  loader can accept a word
i_sof  input  1  word is the first of a frame
i_dest  input  ADDR_WIDTH  destination PE index; all-ones means broadcast
i_inst  input  4  instruction word {class[1:0], dir[1:0]}
i_hold  input  1  PE is executing SORT; blocks writes
i_rd_addr  input  ADDR_WIDTH  PE step counter
o_rd_inst  output  4  instruction at i_rd_addr
o_loaded  output  1  a complete frame is resident
o_busy  output  1  frame load in progress
o_err_count  output  ERR_WIDTH  saturating error count

Behaviour:
- Handshake: a transfer occurs when i_valid & o_ready. o_ready = !i_hold (combinational), so the PE never sees a store change mid-sort.
- A word matches when i_dest == I or i_dest is all-ones. Non-matching words are accepted and ignored, with no state change.
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE or DONE:
  - Matching transfer with i_sof: write mem[0], set wr_ptr=1, clear o_loaded, go to LOAD.
  - Matching transfer without i_sof: stray word. Increment the error count and drop the word.
- LOAD:
  - Matching transfer without i_sof: write mem[wr_ptr], increment wr_ptr.
  - If that write was at wr_ptr == SORT_CYCLES-1: go to DONE and set o_loaded the next cycle.
  - Matching transfer with i_sof: truncated frame. Increment the error count, write mem[0], set wr_ptr=1, stay in LOAD.
- o_busy = (state == LOAD).
- Write latency: a word written at edge t is visible on o_rd_inst from cycle t+1.
- Read port is combinational:
  - o_rd_inst = mem[i_rd_addr] when o_loaded and i_rd_addr < SORT_CYCLES.
  - Otherwise o_rd_inst = 4'b0000 (nop). This covers unloaded or partially loaded stores and out-of-range addresses, including i_rd_addr == SORT_CYCLES.
- o_err_count saturates at all-ones. On simultaneous error sources it increments by 1 per cycle.
- i_hold asserted mid-LOAD: the FSM stays in LOAD with wr_ptr frozen, and loading resumes when i_hold drops.
- Reset values: state=IDLE, wr_ptr=0, o_loaded=0, o_busy=0, o_err_count=0. o_ready follows i_hold. Memory is not reset; the read gating above makes its contents invisible.
- Reset mid-LOAD discards the partial frame, and o_loaded stays 0 until a full frame arrives.
- wr_ptr is ADDR_WIDTH bits. SORT_CYCLES must be <= 2^ADDR_WIDTH (elaboration-time check).

Optional Feature:
INST_CHECK_EN
- Defined:
  - Opcodes 4'b0001, 4'b0010 and 4'b0011 (class 00 with nonzero dir) are illegal.
  - An illegal word in a matching transfer is written as 4'b0000, increments o_err_count, and still advances wr_ptr.
  - A combinational output o_illegal pulses for one cycle on each such transfer.
- Undefined: words are stored verbatim, o_illegal is absent, and illegal codes reach the PE, which treats unmatched codes as hold.

Decomposition:
- Shared package nanci_pkg holds:
  - instruction encodings: nop=0000; slt_*=01xx; sgt_*=10xx; s_*=11xx; dir l=00, r=01, u=10, d=11
  - FSM state enum for IDLE, LOAD, DONE
  - the BROADCAST_ID constant
- One sub-module, inst_store: a SORT_CYCLES x 4 memory with a registered write port and an async read port. It is the unit later swapped for a technology RAM macro.
- Destination match, FSM and error counter live in pe_inst_loader.

Test Plan:
- Full frame to I=5, SORT_CYCLES=8: i_dest=5, i_sof on word 0, words 1100,0100,1001,0000,1111,0110,1010,1101 -> o_loaded=1 the cycle after word 7; reads of addresses 0..7 return those words; address 8 returns 0000.
- Broadcast vs. other PE: frame with i_dest=all-ones loads; frame with i_dest=6 is ignored (o_loaded unchanged, error count 0), and o_ready stays 1 throughout.
- Truncated frame: sof, 3 words, then a new sof and 8 words -> o_err_count=1, o_loaded=1, contents equal the second frame.
- Hold: i_hold=1 after word 3 -> o_ready=0, no writes, and o_rd_inst returns 0000 (not loaded); drop i_hold -> the remaining words complete the load.
- Stray and reset: a word without sof in IDLE -> o_err_count=1; async rst asserted mid-LOAD -> state IDLE, o_loaded=0, o_err_count=0 immediately, without waiting for a clock edge.
- INST_CHECK_EN: word 0010 in a frame -> stored 0000, o_illegal pulses 1 cycle, o_err_count increments, and the frame still completes.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared types for the sort-instruction path: instruction encoding, loader FSM states and the
// broadcast destination id.
package nanci_pkg;

  typedef enum logic [1:0] {ClsNop, ClsSlt, ClsSgt, ClsSwap} inst_class_e;
  typedef enum logic [1:0] {DirL, DirR, DirU, DirD} dir_e;

  typedef struct packed {
    inst_class_e cls;
    dir_e        dir;
  } inst_t;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} load_state_e;

  localparam logic [3:0]  INST_NOP     = 4'b0000;
  localparam logic [31:0] BROADCAST_ID = '1;

  // Class 00 only has a meaning with dir l (plain nop).
  function automatic logic is_illegal(logic [3:0] word);
    inst_t w;
    w = word;
    return (w.cls == ClsNop) && (w.dir != DirL);
  endfunction

endpackage

// File: rtl/pe_inst_loader_if.sv
// Framed instruction stream from the host/configuration bus into a PE loader.
interface pe_inst_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_sof;
  logic [ADDR_WIDTH-1:0] i_dest;
  logic [3:0]            i_inst;

  modport master (output i_valid, output i_sof, output i_dest, output i_inst, input o_ready);
  modport slave  (input i_valid, input i_sof, input i_dest, input i_inst, output o_ready);
endinterface

// File: rtl/inst_store.sv
// Depth x 4 instruction memory: registered write port, asynchronous read port.
module inst_store #(
  parameter int unsigned Depth     = 222,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [3:0]           wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [3:0]           rdata
);

  logic [3:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_inst_loader.sv
// Write side of a PE sort-instruction store; captures frames addressed to PE I or broadcast.
// Optional INST_CHECK_EN replaces illegal opcodes by nop, counts them and adds o_illegal.
module pe_inst_loader
  import nanci_pkg::*;
#(
  parameter int unsigned SORT_CYCLES = 222,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned I           = 0,
  parameter int unsigned ERR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pe_inst_loader_if.slave       bus,
  input  logic                  i_hold,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [3:0]            o_rd_inst,
  output logic                  o_loaded,
  output logic                  o_busy,
  output logic [ERR_WIDTH-1:0]  o_err_count
`ifdef INST_CHECK_EN
  ,
  output logic                  o_illegal
`endif
);

  localparam int unsigned StoreAw = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

  if (64'(SORT_CYCLES) > (64'(1) << ADDR_WIDTH)) begin : g_bad_cfg
    $error("SORT_CYCLES does not fit in ADDR_WIDTH");
  end

  load_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  loaded_q, loaded_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;

  logic                  match, take, err_inc, last;
  logic                  we;
  logic [StoreAw-1:0]    waddr;
  logic [3:0]            wdata, rdata;
  logic                  bad_word;

  assign bus.o_ready = ~i_hold;
  assign match = (bus.i_dest == ADDR_WIDTH'(I)) ||
                 (bus.i_dest == BROADCAST_ID[ADDR_WIDTH-1:0]);
  assign take  = bus.i_valid && bus.o_ready && match;
  assign last  = (wr_ptr_q == ADDR_WIDTH'(SORT_CYCLES - 1));

`ifdef INST_CHECK_EN
  assign bad_word  = is_illegal(bus.i_inst);
  assign o_illegal = we && bad_word;
`else
  assign bad_word  = 1'b0;
`endif

  assign wdata = bad_word ? INST_NOP : bus.i_inst;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    loaded_d = loaded_q;
    we       = 1'b0;
    waddr    = wr_ptr_q[StoreAw-1:0];
    err_inc  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (take) begin
          if (bus.i_sof) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = ADDR_WIDTH'(1);
            loaded_d = 1'b0;
            state_d  = StLoad;
          end else begin
            err_inc = 1'b1;  // stray word outside a frame is dropped
          end
        end
      end
      StLoad: begin
        if (take) begin
          we = 1'b1;
          if (bus.i_sof) begin
            err_inc  = 1'b1;  // previous frame truncated; restart at word 0
            waddr    = '0;
            wr_ptr_d = ADDR_WIDTH'(1);
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (last) begin
              state_d  = StDone;
              loaded_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (we && bad_word) begin
      err_inc = 1'b1;
    end
    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_WIDTH'(1) : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      loaded_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  inst_store #(
    .Depth    (SORT_CYCLES),
    .AddrWidth(StoreAw)
  ) u_store (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(i_rd_addr[StoreAw-1:0]),
    .rdata(rdata)
  );

  // Partially loaded stores and out-of-range steps read as nop.
  assign o_rd_inst   = (loaded_q && ({1'b0, i_rd_addr} < (ADDR_WIDTH + 1)'(SORT_CYCLES))) ?
                       rdata : INST_NOP;
  assign o_loaded    = loaded_q;
  assign o_busy      = (state_q == StLoad);
  assign o_err_count = err_q;

endmodule
